// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter and sequencer for the shared memory bus.
// Serialises CPU (r0) and IO/DMA (r1) accesses, holds the bus for HOLD_CYCLES and returns a one-cycle ack.
//
// state  | meaning
// IDLE   | no transaction; arbitrate on any request
// ACCESS | bus driven with m_en=1, hold_cnt counting down to data capture
// RESP   | owner's ack high for this single cycle
// ERR    | out-of-range address; owner's ack and err high for this single cycle
module mem_bus_arbiter #(
    parameter logic [31:0] MEMSIZE     = 32'h7000,
    parameter bit          PRIO_MODE   = 1'b0,
    parameter int          HOLD_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        r0_req,
    input  logic        r0_rw,
    input  logic [1:0]  r0_size,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_ack,
    output logic        r0_err,
    output logic [31:0] r0_rdata,
    input  logic        r1_req,
    input  logic        r1_rw,
    input  logic [1:0]  r1_size,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_ack,
    output logic        r1_err,
    output logic [31:0] r1_rdata,
    output logic        m_en,
    output logic        m_rw,
    output logic [1:0]  m_size,
    output logic [31:0] m_abus,
    output logic [31:0] m_dout,
    input  logic [31:0] m_din,
    output logic        busy,
    output logic        owner
);

    localparam logic [31:0] ADDR_MAX  = MEMSIZE - 32'd4;
    localparam logic [3:0]  HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    state_t      state, state_nxt;
    logic [3:0]  hold_cnt, hold_cnt_nxt;
    logic        last_served, last_served_nxt;
    logic        owner_nxt, busy_nxt;
    logic        m_en_nxt, m_rw_nxt;
    logic [1:0]  m_size_nxt;
    logic [31:0] m_abus_nxt, m_dout_nxt;
    logic        r0_ack_nxt, r0_err_nxt, r1_ack_nxt, r1_err_nxt;
    logic [31:0] r0_rdata_nxt, r1_rdata_nxt;

    logic        win;
    logic        sel_rw;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr, sel_wdata;

    always_comb begin
        // Round-robin only matters on a tie; a lone requester always wins.
        if (PRIO_MODE)
            win = ~r0_req;
        else if (r0_req && r1_req)
            win = ~last_served;
        else
            win = ~r0_req;

        sel_rw    = win ? r1_rw    : r0_rw;
        sel_size  = win ? r1_size  : r0_size;
        sel_addr  = win ? r1_addr  : r0_addr;
        sel_wdata = win ? r1_wdata : r0_wdata;

        state_nxt       = state;
        hold_cnt_nxt    = hold_cnt;
        last_served_nxt = last_served;
        owner_nxt       = owner;
        m_en_nxt        = m_en;
        m_rw_nxt        = m_rw;
        m_size_nxt      = m_size;
        m_abus_nxt      = m_abus;
        m_dout_nxt      = m_dout;
        r0_rdata_nxt    = r0_rdata;
        r1_rdata_nxt    = r1_rdata;
        r0_ack_nxt      = 1'b0;
        r0_err_nxt      = 1'b0;
        r1_ack_nxt      = 1'b0;
        r1_err_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (r0_req || r1_req) begin
                    owner_nxt = win;
                    if (sel_addr > ADDR_MAX) begin
                        state_nxt       = ERR;
                        last_served_nxt = win;
                        r0_ack_nxt      = ~win;
                        r0_err_nxt      = ~win;
                        r1_ack_nxt      = win;
                        r1_err_nxt      = win;
                    end else begin
                        state_nxt    = ACCESS;
                        m_en_nxt     = 1'b1;
                        m_rw_nxt     = sel_rw;
                        m_size_nxt   = sel_size;
                        m_abus_nxt   = sel_addr;
                        m_dout_nxt   = sel_wdata;
                        hold_cnt_nxt = HOLD_LOAD;
                    end
                end
            end
            ACCESS: begin
                if (hold_cnt != 4'd0) begin
                    hold_cnt_nxt = hold_cnt - 4'd1;
                end else begin
                    if (m_rw) begin
                        if (owner) r1_rdata_nxt = m_din;
                        else       r0_rdata_nxt = m_din;
                    end
                    m_en_nxt        = 1'b0;
                    m_rw_nxt        = 1'b1;
                    r0_ack_nxt      = ~owner;
                    r1_ack_nxt      = owner;
                    last_served_nxt = owner;
                    state_nxt       = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            hold_cnt    <= 4'd0;
            last_served <= 1'b1;
            owner       <= 1'b0;
            busy        <= 1'b0;
            m_en        <= 1'b0;
            m_rw        <= 1'b1;
            m_size      <= 2'b11;
            m_abus      <= 32'd0;
            m_dout      <= 32'd0;
            r0_ack      <= 1'b0;
            r0_err      <= 1'b0;
            r0_rdata    <= 32'd0;
            r1_ack      <= 1'b0;
            r1_err      <= 1'b0;
            r1_rdata    <= 32'd0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_cnt_nxt;
            last_served <= last_served_nxt;
            owner       <= owner_nxt;
            busy        <= busy_nxt;
            m_en        <= m_en_nxt;
            m_rw        <= m_rw_nxt;
            m_size      <= m_size_nxt;
            m_abus      <= m_abus_nxt;
            m_dout      <= m_dout_nxt;
            r0_ack      <= r0_ack_nxt;
            r0_err      <= r0_err_nxt;
            r0_rdata    <= r0_rdata_nxt;
            r1_ack      <= r1_ack_nxt;
            r1_err      <= r1_err_nxt;
            r1_rdata    <= r1_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: instance 0 is round-robin/HOLD=1, instance 1 is fixed-priority/HOLD=3.
// Each instance sits on a byte-addressed bench memory and is checked against a transaction-level model.
module tb_mem_bus_arbiter;

    logic clock = 1'b0;
    logic reset;

    logic        r0_req[2], r0_rw[2], r0_ack[2], r0_err[2];
    logic [1:0]  r0_size[2];
    logic [31:0] r0_addr[2], r0_wdata[2], r0_rdata[2];
    logic        r1_req[2], r1_rw[2], r1_ack[2], r1_err[2];
    logic [1:0]  r1_size[2];
    logic [31:0] r1_addr[2], r1_wdata[2], r1_rdata[2];
    logic        m_en[2], m_rw[2], busy[2], owner[2];
    logic [1:0]  m_size[2];
    logic [31:0] m_abus[2], m_dout[2], m_din[2];

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] LAST_LEGAL = 32'h6FFC;
    int hold_of[2] = '{1, 3};
    bit prio_of[2] = '{1'b0, 1'b1};

    logic [7:0]  phys_mem[2][256];
    logic [7:0]  ref_mem[2][256];
    bit          last_served[2];
    logic [31:0] exp_rdata[2][2];

    always #5 clock = ~clock;

    mem_bus_arbiter #(.MEMSIZE(32'h7000), .PRIO_MODE(1'b0), .HOLD_CYCLES(1)) u_rr (
        .clock(clock), .reset(reset),
        .r0_req(r0_req[0]), .r0_rw(r0_rw[0]), .r0_size(r0_size[0]), .r0_addr(r0_addr[0]),
        .r0_wdata(r0_wdata[0]), .r0_ack(r0_ack[0]), .r0_err(r0_err[0]), .r0_rdata(r0_rdata[0]),
        .r1_req(r1_req[0]), .r1_rw(r1_rw[0]), .r1_size(r1_size[0]), .r1_addr(r1_addr[0]),
        .r1_wdata(r1_wdata[0]), .r1_ack(r1_ack[0]), .r1_err(r1_err[0]), .r1_rdata(r1_rdata[0]),
        .m_en(m_en[0]), .m_rw(m_rw[0]), .m_size(m_size[0]), .m_abus(m_abus[0]),
        .m_dout(m_dout[0]), .m_din(m_din[0]), .busy(busy[0]), .owner(owner[0])
    );

    mem_bus_arbiter #(.MEMSIZE(32'h7000), .PRIO_MODE(1'b1), .HOLD_CYCLES(3)) u_pr (
        .clock(clock), .reset(reset),
        .r0_req(r0_req[1]), .r0_rw(r0_rw[1]), .r0_size(r0_size[1]), .r0_addr(r0_addr[1]),
        .r0_wdata(r0_wdata[1]), .r0_ack(r0_ack[1]), .r0_err(r0_err[1]), .r0_rdata(r0_rdata[1]),
        .r1_req(r1_req[1]), .r1_rw(r1_rw[1]), .r1_size(r1_size[1]), .r1_addr(r1_addr[1]),
        .r1_wdata(r1_wdata[1]), .r1_ack(r1_ack[1]), .r1_err(r1_err[1]), .r1_rdata(r1_rdata[1]),
        .m_en(m_en[1]), .m_rw(m_rw[1]), .m_size(m_size[1]), .m_abus(m_abus[1]),
        .m_dout(m_dout[1]), .m_din(m_din[1]), .busy(busy[1]), .owner(owner[1])
    );

    // Bench memory: little-endian bytes, right-aligned data, zero-extended reads.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            logic [31:0] v;
            if (m_en[d] && !m_rw[d])
                for (int k = 0; k <= int'(m_size[d]); k++)
                    phys_mem[d][(m_abus[d] + k) & 32'hFF] = m_dout[d][8*k +: 8];
            v = 32'd0;
            for (int k = 0; k <= int'(m_size[d]); k++)
                v[8*k +: 8] = phys_mem[d][(m_abus[d] + k) & 32'hFF];
            m_din[d] = v;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(int d, logic [31:0] a, logic [1:0] s);
        logic [31:0] v = 32'd0;
        for (int k = 0; k <= int'(s); k++)
            v = v | (32'(ref_mem[d][(a + k) & 32'hFF]) << (8 * k));
        return v;
    endfunction

    task automatic ref_write(int d, logic [31:0] a, logic [1:0] s, logic [31:0] wd);
        for (int k = 0; k <= int'(s); k++)
            ref_mem[d][(a + k) & 32'hFF] = 8'((wd >> (8 * k)) & 32'hFF);
    endtask

    function automatic int pick(int d, bit q0, bit q1);
        if (prio_of[d]) return q0 ? 0 : 1;
        if (q0 && q1)   return last_served[d] ? 0 : 1;
        return q0 ? 0 : 1;
    endfunction

    task automatic set_req(int d, int who, bit req, bit rw, logic [1:0] sz,
                           logic [31:0] a, logic [31:0] wd);
        if (who == 0) begin
            r0_req[d] = req; r0_rw[d] = rw; r0_size[d] = sz; r0_addr[d] = a; r0_wdata[d] = wd;
        end else begin
            r1_req[d] = req; r1_rw[d] = rw; r1_size[d] = sz; r1_addr[d] = a; r1_wdata[d] = wd;
        end
    endtask

    function automatic logic get_ack(int d, int who);
        return (who == 0) ? r0_ack[d] : r1_ack[d];
    endfunction

    function automatic logic get_err(int d, int who);
        return (who == 0) ? r0_err[d] : r1_err[d];
    endfunction

    function automatic logic [31:0] get_rdata(int d, int who);
        return (who == 0) ? r0_rdata[d] : r1_rdata[d];
    endfunction

    task automatic check_reset_state(int d);
        check("rst_m_en",   32'(m_en[d]),   32'd0);
        check("rst_m_rw",   32'(m_rw[d]),   32'd1);
        check("rst_m_size", 32'(m_size[d]), 32'd3);
        check("rst_m_abus", m_abus[d],      32'd0);
        check("rst_m_dout", m_dout[d],      32'd0);
        check("rst_busy",   32'(busy[d]),   32'd0);
        check("rst_owner",  32'(owner[d]),  32'd0);
        check("rst_acks",   {r0_ack[d], r0_err[d], r1_ack[d], r1_err[d]}, 32'd0);
        check("rst_r0_rdata", r0_rdata[d], 32'd0);
        check("rst_r1_rdata", r1_rdata[d], 32'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
    task automatic run_single(int d, int who, bit rw, logic [1:0] sz, logic [31:0] a,
                              logic [31:0] wd, bit drop_early);
        int h = hold_of[d];
        set_req(d, who, 1'b1, rw, sz, a, wd);
        @(posedge clock);
        @(negedge clock);
        if (drop_early) set_req(d, who, 1'b0, ~rw, ~sz, ~a, ~wd);
        if (a > LAST_LEGAL) begin
            check("err_ack",   32'(get_ack(d, who)), 32'd1);
            check("err_err",   32'(get_err(d, who)), 32'd1);
            check("err_other", 32'(get_ack(d, 1 - who)), 32'd0);
            check("err_m_en",  32'(m_en[d]), 32'd0);
            check("err_owner", 32'(owner[d]), 32'(who));
            check("err_rdata", get_rdata(d, who), exp_rdata[d][who]);
            last_served[d] = (who != 0);
        end else begin
            for (int k = 0; k < h; k++) begin
                check("acc_m_en",   32'(m_en[d]),   32'd1);
                check("acc_m_abus", m_abus[d],      a);
                check("acc_m_rw",   32'(m_rw[d]),   32'(rw));
                check("acc_m_size", 32'(m_size[d]), 32'(sz));
                if (!rw) check("acc_m_dout", m_dout[d], wd);
                check("acc_no_ack", 32'(r0_ack[d] | r1_ack[d]), 32'd0);
                check("acc_busy",   32'(busy[d]),  32'd1);
                check("acc_owner",  32'(owner[d]), 32'(who));
                @(negedge clock);
            end
            if (rw) exp_rdata[d][who] = ref_read(d, a, sz);
            else    ref_write(d, a, sz, wd);
            last_served[d] = (who != 0);
            check("resp_ack",   32'(get_ack(d, who)), 32'd1);
            check("resp_err",   32'(get_err(d, who)), 32'd0);
            check("resp_other", 32'(get_ack(d, 1 - who)), 32'd0);
            check("resp_m_en",  32'(m_en[d]), 32'd0);
            check("resp_m_rw",  32'(m_rw[d]), 32'd1);
            check("resp_rdata", get_rdata(d, who), exp_rdata[d][who]);
        end
        if (!drop_early) set_req(d, who, 1'b0, rw, sz, a, wd);
        @(negedge clock);
        check("end_ack",  32'(r0_ack[d] | r1_ack[d]), 32'd0);
        check("end_busy", 32'(busy[d]), 32'd0);
    endtask

    // Both requesters hold reads for n grants; the model predicts the winner of each.
    task automatic run_both(int d, int n);
        logic [31:0] a0 = 32'($urandom_range(0, 252));
        logic [31:0] a1 = 32'($urandom_range(0, 252));
        set_req(d, 0, 1'b1, 1'b1, 2'b11, a0, 32'd0);
        set_req(d, 1, 1'b1, 1'b1, 2'b10, a1, 32'd0);
        for (int t = 0; t < n; t++) begin
            int  exp_w = pick(d, 1'b1, 1'b1);
            bit  found = 1'b0;
            for (int c = 0; c < 20 && !found; c++) begin
                @(negedge clock);
                found = r0_ack[d] | r1_ack[d];
            end
            check("arb_timeout", 32'(found), 32'd1);
            if (!found) return;
            check("arb_winner", 32'(r1_ack[d]), 32'(exp_w));
            check("arb_single_ack", 32'(r0_ack[d] & r1_ack[d]), 32'd0);
            check("arb_m_en", 32'(m_en[d]), 32'd0);
            exp_rdata[d][exp_w] = (exp_w == 0) ? ref_read(d, a0, 2'b11) : ref_read(d, a1, 2'b10);
            check("arb_rdata", get_rdata(d, exp_w), exp_rdata[d][exp_w]);
            last_served[d] = (exp_w != 0);
        end
        set_req(d, 0, 1'b0, 1'b1, 2'b11, a0, 32'd0);
        set_req(d, 1, 1'b0, 1'b1, 2'b10, a1, 32'd0);
        @(negedge clock);
        check("arb_idle", 32'(busy[d]), 32'd0);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            last_served[d] = 1'b1;
            exp_rdata[d][0] = 32'd0;
            exp_rdata[d][1] = 32'd0;
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            set_req(d, 0, 1'b0, 1'b1, 2'b00, 32'd0, 32'd0);
            set_req(d, 1, 1'b0, 1'b1, 2'b00, 32'd0, 32'd0);
            for (int i = 0; i < 256; i++) begin
                phys_mem[d][i] = 8'($urandom);
                ref_mem[d][i]  = phys_mem[d][i];
            end
            {phys_mem[d][16], phys_mem[d][17], phys_mem[d][18], phys_mem[d][19]} = 32'hEFBEADDE;
            {ref_mem[d][16],  ref_mem[d][17],  ref_mem[d][18],  ref_mem[d][19]}  = 32'hEFBEADDE;
        end
        model_reset();
        repeat (3) @(negedge clock);
        check_reset_state(0);
        check_reset_state(1);
        reset = 1'b1;
        @(negedge clock);

        // Directed: single read, byte write then byte read-back.
        run_single(0, 0, 1'b1, 2'b11, 32'h10, 32'd0, 1'b0);
        check("word_read", r0_rdata[0], 32'hDEADBEEF);
        run_single(0, 1, 1'b0, 2'b00, 32'h20, 32'h123456A5, 1'b0);
        run_single(0, 1, 1'b1, 2'b00, 32'h20, 32'd0, 1'b0);
        check("byte_readback", r1_rdata[0], 32'h000000A5);

        // Contention: round-robin alternates, fixed priority keeps r0.
        run_both(0, 4);
        run_both(1, 4);

        // Address range edges.
        run_single(0, 0, 1'b1, 2'b11, 32'h6FFD, 32'd0, 1'b0);
        run_single(0, 1, 1'b1, 2'b11, LAST_LEGAL, 32'd0, 1'b0);
        run_single(1, 1, 1'b0, 2'b11, 32'hFFFF_FFFF, 32'h5555_AAAA, 1'b0);

        // Long hold with request dropped and inputs scrambled after the grant.
        run_single(1, 0, 1'b1, 2'b11, 32'h40, 32'd0, 1'b1);
        run_single(1, 0, 1'b0, 2'b01, 32'h44, 32'hCAFE_F00D, 1'b1);
        run_single(1, 0, 1'b1, 2'b11, 32'h44, 32'd0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int          d   = int'($urandom_range(0, 1));
            int          who = int'($urandom_range(0, 1));
            logic [31:0] a;
            if ($urandom_range(0, 7) == 0) a = 32'h6FFD + 32'($urandom_range(0, 32'h0FFF_0000));
            else                           a = 32'($urandom_range(0, 255));
            run_single(d, who, 1'($urandom), 2'($urandom), a, $urandom, 1'($urandom));
        end

        // Asynchronous reset in the middle of an access.
        set_req(1, 0, 1'b1, 1'b1, 2'b11, 32'h08, 32'd0);
        @(posedge clock);
        @(negedge clock);
        check("pre_rst_m_en", 32'(m_en[1]), 32'd1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("async_m_en", 32'(m_en[1]), 32'd0);
        check("async_busy", 32'(busy[1]), 32'd0);
        check("async_ack",  32'(r0_ack[1] | r1_ack[1]), 32'd0);
        check("async_m_rw", 32'(m_rw[1]), 32'd1);
        set_req(1, 0, 1'b0, 1'b1, 2'b11, 32'h08, 32'd0);
        @(negedge clock);
        check_reset_state(1);
        reset = 1'b1;
        @(negedge clock);
        run_single(1, 1, 1'b1, 2'b11, 32'h30, 32'd0, 1'b0);
        run_both(0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
